// File: rtl/key_reader_pkg.sv
// Shared types and helpers for the push-button reader: lane state encoding,
// the electrical level of a pressed key, and width helpers for the counters.
package key_reader_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } lane_state_e;

  // Board keys pull low when pressed.
  localparam logic KEY_PRESSED_LVL = 1'b0;

  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_lane.sv
// One key: 2-flop synchroniser, debounce FSM, level and press/release strobes.
// Auto-repeat of press strobes while held is built when KEY_READER_REPEAT_EN is defined.
module key_lane
  import key_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic press_next
);

  localparam int CNT_W = clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync;
  logic             pressed;
  lane_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt;
  logic             release_nxt;

`ifdef KEY_READER_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_MAX = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_MAX  = CNT_W'(REPEAT_RATE);

  logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;
  logic             rep_rate, rep_rate_nxt;
`endif

  // Presetting to "released" keeps a key held through reset from looking like a fresh edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], key_n};
  end

  assign pressed = (sync[1] == KEY_PRESSED_LVL);

  // NOTE: every state flop uses <= so all lanes update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef KEY_READER_REPEAT_EN
      rep_cnt     <= '0;
      rep_rate    <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_level   <= level_nxt;
      key_press   <= press_next;
      key_release <= release_nxt;
`ifdef KEY_READER_REPEAT_EN
      rep_cnt     <= rep_cnt_nxt;
      rep_rate    <= rep_rate_nxt;
`endif
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = key_level;
    press_next  = 1'b0;
    release_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_MAX) begin
          state_nxt  = HELD;
          cnt_nxt    = '0;
          level_nxt  = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_MAX) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
    endcase

`ifdef KEY_READER_REPEAT_EN
    // Repeat timing spans HELD and RELEASE_WAIT so a release bounce does not restart it.
    rep_cnt_nxt  = rep_cnt;
    rep_rate_nxt = rep_rate;
    if (state == PRESS_WAIT && state_nxt == HELD) begin
      rep_cnt_nxt  = CNT_ONE;
      rep_rate_nxt = 1'b0;
    end else if (state == HELD || state == RELEASE_WAIT) begin
      if (rep_cnt == (rep_rate ? RATE_MAX : DELAY_MAX)) begin
        rep_cnt_nxt  = CNT_ONE;
        rep_rate_nxt = 1'b1;
        if (state_nxt != IDLE) press_next = 1'b1;
      end else begin
        rep_cnt_nxt = rep_cnt + CNT_ONE;
      end
    end else begin
      rep_cnt_nxt  = '0;
      rep_rate_nxt = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/key_reader.sv
// Debounced push-button reader: NUM_KEYS independent lanes plus a combined press strobe.
// Define KEY_READER_REPEAT_EN to enable auto-repeat press strobes on held keys.
module key_reader
  import key_reader_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_press
);

  logic [NUM_KEYS-1:0] press_next;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_n      (key_n[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .press_next (press_next[i])
    );
  end

  // Registered from the lanes' next-press terms so it lines up with key_press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_press <= 1'b0;
    else          any_press <= |press_next;
  end

endmodule

// File: tb/tb_key_reader.sv
// Scoreboard bench for key_reader: stimulus queues expected strobes with their cycle,
// a negedge monitor pops and compares whenever a press or release strobe appears.
module tb_key_reader;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam int LAT = DEB + 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key_n = 4'b0000;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       any_press;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   t;

  key_reader #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic [3:0] p, input logic [3:0] r,
                          input logic [3:0] l);
    exp_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    e.level = l;
    q.push_back(e);
  endtask

  // Expected strobes for one hold: press at p, repeats before r, release at r if requested.
  task automatic push_hold(input logic [3:0] mask, input int p, input int r, input bit with_rel);
    push_exp(p, mask, 4'b0000, mask);
`ifdef KEY_READER_REPEAT_EN
    for (int c = p + RD; c < r; c += RR) push_exp(c, mask, 4'b0000, mask);
`endif
    if (with_rel) push_exp(r, 4'b0000, mask, 4'b0000);
  endtask

  task automatic wait_until(input int at);
    while (cyc < at) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] v, output int when);
    @(posedge clk);
    #1;
    key_n = v;
    when  = cyc;
  endtask

  task automatic drive_at(input int at, input logic [3:0] v);
    wait_until(at);
    key_n = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   key_level,   4'b0000);
    check({tag, "_press"},   key_press,   4'b0000);
    check({tag, "_release"}, key_release, 4'b0000);
    check({tag, "_any"},     any_press,   1'b0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("missed_strobe_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (key_press != 4'b0000 || key_release != 4'b0000) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", {key_press, key_release}, 0);
        end else begin
          mon_e = q.pop_front();
          check("strobe_cycle", cyc,         mon_e.cyc);
          check("key_press",    key_press,   mon_e.press);
          check("key_release",  key_release, mon_e.rel);
          check("key_level",    key_level,   mon_e.level);
          check("any_press",    any_press,   |mon_e.press);
        end
      end
    end
  end

  initial begin
    // Reset with all keys low, then release reset with keys high: nothing may happen.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    key_n = 4'hF;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_all_zero("idle");

    // Clean press and release on key 0.
    drive(4'b1110, t);
    push_hold(4'b0001, t + LAT, t + 20 + LAT, 1'b1);
    wait_until(t + 12);
    check("held_level_k0", key_level, 4'b0001);
    drive_at(t + 20, 4'hF);
    wait_until(t + 20 + LAT + 3);
    check("released_level_k0", key_level, 4'b0000);

    // Three-sample glitch on key 1 is rejected.
    drive(4'b1101, t);
    drive_at(t + 3, 4'hF);
    wait_until(t + 15);
    check("glitch_level_k1", key_level, 4'b0000);

    // Two-sample release bounce while key 1 is held gives no release strobe.
    drive(4'b1101, t);
    push_hold(4'b0010, t + LAT, t + 30 + LAT, 1'b1);
    drive_at(t + 12, 4'hF);
    drive_at(t + 14, 4'b1101);
    wait_until(t + 25);
    check("bounce_level_k1", key_level, 4'b0010);
    drive_at(t + 30, 4'hF);
    wait_until(t + 30 + LAT + 3);
    check("released_level_k1", key_level, 4'b0000);

    // Keys 1 and 3 pressed together.
    drive(4'b0101, t);
    push_hold(4'b1010, t + LAT, t + 20 + LAT, 1'b1);
    drive_at(t + 20, 4'hF);
    wait_until(t + 20 + LAT + 3);

    // Key 3 held 25 cycles past acceptance; a repeat due on the release cycle is dropped.
    drive(4'b0111, t);
    push_hold(4'b1000, t + LAT, t + 25 + LAT, 1'b1);
    drive_at(t + 25, 4'hF);
    wait_until(t + 25 + LAT + 3);
    check("released_level_k3", key_level, 4'b0000);

    // Reset while key 2 is held: silent abort, then the still-held key is re-accepted.
    drive(4'b1011, t);
    push_hold(4'b0100, t + LAT, t + LAT + 5, 1'b0);
    wait_until(t + LAT + 4);
    check("pre_reset_level_k2", key_level, 4'b0100);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_hold_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    t = cyc;
    push_hold(4'b0100, t + LAT, t + 30 + LAT, 1'b1);
    drive_at(t + 30, 4'hF);
    wait_until(t + 30 + LAT + 5);
    check("final_level", key_level, 4'b0000);
    check("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_reader.md
Name: key_reader

Overview:
- Input-side counterpart to the LED blinker: the blinker writes the board LEDs, and this block reads the board push-buttons (KEY, active-low, asynchronous to clk).
- Each key is synchronised, debounced with a per-key state machine, and presented as a clean level plus single-cycle press and release strobes.
- Replaces the bare edge-to-pulse oneshot path that feeds delay_ctrl.
- An optional auto-repeat mode emits additional press strobes while a key is held.

Parameters:
- NUM_KEYS, 4, number of independent key lanes.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a change (10 ms at 50 MHz). Must be >= 1.
- REPEAT_DELAY, 25000000, cycles in HELD before the first repeat strobe (0.5 s). Used only with the optional feature.
- REPEAT_RATE, 5000000, cycles between subsequent repeat strobes (0.1 s). Must be >= 1. Used only with the optional feature.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset_n  input  1  asynchronous active-low reset.
- key_n  input  NUM_KEYS  raw board keys, 0 = pressed, asynchronous.
- key_level  output  NUM_KEYS  debounced state, 1 = pressed.
- key_press  output  NUM_KEYS  1-cycle strobe on accepted press (and on repeats if enabled).
- key_release  output  NUM_KEYS  1-cycle strobe on accepted release.
- any_press  output  1  OR of key_press, registered in the same cycle as key_press.

Behaviour:
- Interface (decided): one clock, clk; reset_n is asynchronous, active-low.
- Reset: sync flops preset to released (1); all lanes go to IDLE; counters 0; all outputs 0.
  - Reset asserted mid-debounce or mid-hold aborts the lane silently: no release strobe.
- Synchroniser: 2-flop chain per key. key_s is the second-flop output.
- Per-lane FSM, counter width clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)+1):
  - IDLE: if key_s = pressed, go to PRESS_WAIT with cnt = 1.
  - PRESS_WAIT:
    - if key_s = released, go to IDLE with cnt = 0; glitch rejected, no strobe;
    - else if cnt = DEBOUNCE_CYCLES, go to HELD, key_level <= 1, key_press <= 1 for one cycle;
    - else cnt++.
  - HELD: if key_s = released, go to RELEASE_WAIT with cnt = 1.
  - RELEASE_WAIT:
    - if key_s = pressed, return to HELD; no strobe; repeat counter not restarted;
    - else if cnt = DEBOUNCE_CYCLES, go to IDLE, key_level <= 0, key_release <= 1 for one cycle;
    - else cnt++.
- DEBOUNCE_CYCLES = 1 edge case: the PRESS_WAIT/RELEASE_WAIT check passes on entry to those states, with no extra wait.
- Latency:
  - Defining edge E0 as the first clk edge sampling key_n = 0, then key_s is pressed after E1 and key_press is high after edge E(DEBOUNCE_CYCLES+2), for exactly one cycle.
  - Release latency is symmetric.
- Strobes are registered outputs. key_press and key_release are never high together on one lane.
- Lanes are fully independent; simultaneous presses on several keys give simultaneous strobes.

Optional Feature:
- Macro: KEY_READER_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs from entry into HELD.
  - At REPEAT_DELAY cycles it strobes key_press, then again every REPEAT_RATE cycles while the lane stays in HELD or RELEASE_WAIT.
  - The counter clears on IDLE.
  - A repeat strobe due in the same cycle the lane enters IDLE is suppressed; the release wins.
- Undefined: exactly one key_press per accepted press; repeat logic and counters are absent; REPEAT_* parameters are ignored.

Decomposition:
- Package key_reader_pkg holds:
  - lane state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3);
  - KEY_PRESSED_LVL = 1'b0 constant;
  - clog2 helper function.
- Sub-module key_lane: synchroniser, FSM, counters and strobes for one key. The top instantiates NUM_KEYS lanes in a generate loop and ORs key_press into any_press.

Test Plan:
- Reset and idle: DEBOUNCE_CYCLES=4, reset_n low with key_n=4'b0000, then release reset with keys held high -> all outputs 0; no strobe after reset deassertion.
- Clean press/release: key_n[0] falls at E0 and is held 20 cycles -> key_press[0] high only after E6, key_level[0]=1. Rise -> key_release[0] one pulse 6 edges later, key_level[0]=0.
- Glitch rejection: key_n[1] low for 3 cycles, then high -> no strobes, key_level[1] stays 0. Release bounce of 2 cycles while held -> no release strobe.
- Simultaneous: key_n=4'b0101 falls together -> key_press=4'b1010 in the same cycle, any_press=1 for one cycle.
- Reset mid-hold: key_n[2] accepted as pressed, then reset_n pulsed low -> key_level[2]=0, no key_release[2]. With the key still held after reset, key_press[2] is reissued after DEBOUNCE_CYCLES+2.
- With KEY_READER_REPEAT_EN: REPEAT_DELAY=10, REPEAT_RATE=3, key_n[3] held 25 cycles past acceptance -> press strobes at +0, +10, +13, +16, +19, +22. Without the macro -> only the +0 strobe.
